// File: rtl/mem_access_stage.sv
// MEM pipeline stage: services loads/stores over a req/ack data-memory port,
// stalls upstream while a request is outstanding, and registers the MEM/WB bundle.
module mem_access_stage #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] ALUres_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [4:0]        RDaddr_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] ALUres_o,
    output logic [DATA_W-1:0] MemData_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [4:0]        RDaddr_o,
    output logic              misalign_o,
    output logic              err_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            stateR;
    logic [CNT_W-1:0]  cntR;
    logic [DATA_W-1:0] aluR;
    logic              regWriteR;
    logic              memtoRegR;
    logic [4:0]        rdR;

    logic memopS;
    logic alignedS;
    logic timeoutS;
    logic stallS;

    function automatic logic [DATA_W-1:0] wordAlign(input logic [DATA_W-1:0] addr);
        wordAlign = {addr[DATA_W-1:2], 2'b00};
    endfunction

    assign memopS   = MemRead_i | MemWrite_i;
    assign alignedS = (ALUres_i[1:0] == 2'b00);
    assign timeoutS = (cntR == CNT_LAST);
    assign stall_o  = stallS;

    // Upstream freeze: held while a request is pending, released on ack or abort.
    always_comb begin
        stallS = 1'b0;
        case (stateR)
            IDLE: begin
                if (memopS && alignedS) begin
                    stallS = 1'b1;
                end else begin
                    stallS = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    stallS = 1'b0;
                end else if (timeoutS) begin
                    stallS = 1'b0;
                end else begin
                    stallS = 1'b1;
                end
            end
            default: stallS = 1'b0;
        endcase
    end

    // Request FSM, timeout counter and MEM/WB pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateR      <= IDLE;
            cntR        <= '0;
            aluR        <= '0;
            regWriteR   <= 1'b0;
            memtoRegR   <= 1'b0;
            rdR         <= 5'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ALUres_o    <= '0;
            MemData_o   <= '0;
            RegWrite_o  <= 1'b0;
            MemtoReg_o  <= 1'b0;
            RDaddr_o    <= 5'd0;
            misalign_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (stateR)
                IDLE: begin
                    cntR <= '0;
                    if (!memopS) begin
                        ALUres_o   <= ALUres_i;
                        RegWrite_o <= RegWrite_i;
                        MemtoReg_o <= MemtoReg_i;
                        RDaddr_o   <= RDaddr_i;
                        MemData_o  <= '0;
                    end else if (alignedS) begin
                        // A store wins when both read and write are flagged.
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= wordAlign(ALUres_i);
                        mem_wdata_o <= RS2data_i;
                        aluR        <= ALUres_i;
                        regWriteR   <= RegWrite_i;
                        memtoRegR   <= MemtoReg_i;
                        rdR         <= RDaddr_i;
                        RegWrite_o  <= 1'b0;
                        MemtoReg_o  <= 1'b0;
                        stateR      <= BUSY;
                    end else begin
                        misalign_o <= 1'b1;
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_req_o  <= 1'b0;
                        ALUres_o   <= aluR;
                        RegWrite_o <= regWriteR;
                        MemtoReg_o <= memtoRegR;
                        RDaddr_o   <= rdR;
                        MemData_o  <= mem_we_o ? '0 : mem_rdata_i;
                        cntR       <= '0;
                        stateR     <= IDLE;
                    end else if (timeoutS) begin
                        mem_req_o  <= 1'b0;
                        err_o      <= 1'b1;
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                        cntR       <= '0;
                        stateR     <= IDLE;
                    end else begin
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                        cntR       <= cntR + CNT_W'(1);
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    cntR      <= '0;
                    stateR    <= IDLE;
                end
            endcase
        end
    end

endmodule
